// File: rtl/sound_fx_player.sv
// Piezo sound-effect player: plays Perfect (two tones with a gap), Good and Miss effects
// as square waves, with priority-based preemption of the effect currently playing.
module sound_fx_player #(
    parameter int unsigned HALF_PERF1 = 23878,
    parameter int unsigned HALF_PERF2 = 18954,
    parameter int unsigned HALF_GOOD  = 28409,
    parameter int unsigned HALF_MISS  = 113636,
    parameter int unsigned TONE_LEN   = 4000000,
    parameter int unsigned GAP_LEN    = 500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Sound_Cmd,
    input  logic       i_Enable,
    output logic       o_Piezo,
    output logic       o_Busy,
    output logic [1:0] o_Cur_Cmd
);

    typedef enum logic [1:0] {StIdle, StTone1, StGap, StTone2} state_e;

    localparam logic [1:0] CmdPerfect = 2'd1;
    localparam logic [1:0] CmdGood    = 2'd2;
    localparam logic [1:0] CmdMiss    = 2'd3;

    localparam logic [31:0] HalfPerf1Last = 32'(HALF_PERF1 - 1);
    localparam logic [31:0] HalfPerf2Last = 32'(HALF_PERF2 - 1);
    localparam logic [31:0] HalfGoodLast  = 32'(HALF_GOOD - 1);
    localparam logic [31:0] HalfMissLast  = 32'(HALF_MISS - 1);
    localparam logic [31:0] ToneLast      = 32'(TONE_LEN - 1);
    localparam logic [31:0] MissToneLast  = 32'(2 * TONE_LEN - 1);
    localparam logic [31:0] GapLast       = 32'(GAP_LEN - 1);

    state_e      state_q, state_d;
    logic [31:0] half_cnt_q, half_cnt_d;
    logic [31:0] dur_cnt_q, dur_cnt_d;
    logic        piezo_q, piezo_d;
    logic        busy_q, busy_d;
    logic [1:0]  cur_q, cur_d;
    logic [31:0] half_last;
    logic [31:0] dur_last;
    logic        accept;

    // Higher value wins: Miss > Perfect > Good.
    function automatic logic [1:0] prio(input logic [1:0] cmd);
        case (cmd)
            CmdMiss:    return 2'd3;
            CmdPerfect: return 2'd2;
            CmdGood:    return 2'd1;
            default:    return 2'd0;
        endcase
    endfunction

    always_comb begin
        half_last = HalfMissLast;
        case (cur_q)
            CmdPerfect: half_last = (state_q == StTone2) ? HalfPerf2Last : HalfPerf1Last;
            CmdGood:    half_last = HalfGoodLast;
            default:    half_last = HalfMissLast;
        endcase

        if (state_q == StGap) begin
            dur_last = GapLast;
        end else if (cur_q == CmdMiss) begin
            dur_last = MissToneLast;
        end else begin
            dur_last = ToneLast;
        end
    end

    assign accept = (i_Sound_Cmd != 2'd0) &&
                    ((state_q == StIdle) || (prio(i_Sound_Cmd) >= prio(cur_q)));

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        piezo_d    = piezo_q;
        cur_d      = cur_q;

        if (!i_Enable) begin
            state_d    = StIdle;
            half_cnt_d = '0;
            dur_cnt_d  = '0;
            piezo_d    = 1'b0;
            cur_d      = 2'd0;
        end else if (accept) begin
            // Checked before the end-of-effect path so a last-cycle command restarts seamlessly.
            state_d    = StTone1;
            half_cnt_d = '0;
            dur_cnt_d  = '0;
            piezo_d    = 1'b0;
            cur_d      = i_Sound_Cmd;
        end else begin
            case (state_q)
                StTone1, StTone2: begin
                    if (half_cnt_q == half_last) begin
                        half_cnt_d = '0;
                        piezo_d    = ~piezo_q;
                    end else begin
                        half_cnt_d = half_cnt_q + 32'd1;
                    end

                    if (dur_cnt_q == dur_last) begin
                        half_cnt_d = '0;
                        dur_cnt_d  = '0;
                        piezo_d    = 1'b0;
                        if ((state_q == StTone1) && (cur_q == CmdPerfect)) begin
                            state_d = StGap;
                        end else begin
                            state_d = StIdle;
                            cur_d   = 2'd0;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + 32'd1;
                    end
                end
                StGap: begin
                    piezo_d = 1'b0;
                    if (dur_cnt_q == dur_last) begin
                        state_d    = StTone2;
                        half_cnt_d = '0;
                        dur_cnt_d  = '0;
                    end else begin
                        dur_cnt_d = dur_cnt_q + 32'd1;
                    end
                end
                default: begin
                    half_cnt_d = '0;
                    dur_cnt_d  = '0;
                    piezo_d    = 1'b0;
                    cur_d      = 2'd0;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= StIdle;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
            piezo_q    <= 1'b0;
            busy_q     <= 1'b0;
            cur_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            piezo_q    <= piezo_d;
            busy_q     <= busy_d;
            cur_q      <= cur_d;
        end
    end

    assign o_Piezo   = piezo_q;
    assign o_Busy    = busy_q;
    assign o_Cur_Cmd = cur_q;

endmodule

// File: tb/tb_sound_fx_player.sv
// Bench for sound_fx_player: constant-vector table, directed corner sequences and a random
// run, all against an elapsed-time model of each effect.
module tb_sound_fx_player;

    localparam int HP1 = 5;
    localparam int HP2 = 4;
    localparam int HG  = 7;
    localparam int HM  = 20;
    localparam int TL  = 100;
    localparam int GL  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       en = 1'b1;
    logic       piezo;
    logic       busy;
    logic [1:0] cur;

    int n_checks = 0;
    int n_errors = 0;

    // Model: effect being played (0 = idle) and cycles elapsed since it started.
    int m_cmd = 0;
    int m_e = 0;

    always #5 clk = ~clk;

    sound_fx_player #(
        .HALF_PERF1 (HP1),
        .HALF_PERF2 (HP2),
        .HALF_GOOD  (HG),
        .HALF_MISS  (HM),
        .TONE_LEN   (TL),
        .GAP_LEN    (GL)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst_n),
        .i_Sound_Cmd (cmd),
        .i_Enable    (en),
        .o_Piezo     (piezo),
        .o_Busy      (busy),
        .o_Cur_Cmd   (cur)
    );

    typedef struct {
        logic [1:0] cmd;
        int         wait_cyc;
        logic       busy;
        logic       piezo;
        logic [1:0] cur;
    } vec_t;

    vec_t vecs[18];

    function automatic int prio(input int c);
        case (c)
            3:       return 3;
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int total_len(input int c);
        case (c)
            1:       return TL + GL + TL;
            2:       return TL;
            3:       return 2 * TL;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_piezo(input int c, input int e);
        case (c)
            1: begin
                if (e < TL) return (e / HP1) % 2;
                if (e < TL + GL) return 0;
                return ((e - TL - GL) / HP2) % 2;
            end
            2:       return (e / HG) % 2;
            3:       return (e / HM) % 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_busy", int'(busy), (m_cmd != 0) ? 1 : 0);
        check("model_cur", int'(cur), m_cmd);
        check("model_piezo", int'(piezo), exp_piezo(m_cmd, m_e));
    endtask

    task automatic model_edge();
        if (!rst_n || !en) begin
            m_cmd = 0;
            m_e = 0;
        end else if (cmd != 2'd0 && (m_cmd == 0 || prio(int'(cmd)) >= prio(m_cmd))) begin
            m_cmd = int'(cmd);
            m_e = 0;
        end else if (m_cmd != 0) begin
            m_e++;
            if (m_e >= total_len(m_cmd)) begin
                m_cmd = 0;
                m_e = 0;
            end
        end
    endtask

    // Drive a one-cycle command, clock once, update model, compare.
    task automatic step(input logic [1:0] c);
        cmd = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        cmd = 2'd0;
    endtask

    task automatic go_idle();
        en = 1'b0;
        step(2'd0);
        en = 1'b1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_piezo"}, int'(piezo), 0);
        check({name, "_cur"}, int'(cur), 0);
    endtask

    initial begin
        vecs[0]  = '{2'd2, 0,   1'b1, 1'b0, 2'd2};
        vecs[1]  = '{2'd2, 6,   1'b1, 1'b0, 2'd2};
        vecs[2]  = '{2'd2, 7,   1'b1, 1'b1, 2'd2};
        vecs[3]  = '{2'd2, 14,  1'b1, 1'b0, 2'd2};
        vecs[4]  = '{2'd2, 99,  1'b1, 1'b0, 2'd2};
        vecs[5]  = '{2'd2, 100, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{2'd1, 5,   1'b1, 1'b1, 2'd1};
        vecs[7]  = '{2'd1, 99,  1'b1, 1'b1, 2'd1};
        vecs[8]  = '{2'd1, 100, 1'b1, 1'b0, 2'd1};
        vecs[9]  = '{2'd1, 109, 1'b1, 1'b0, 2'd1};
        vecs[10] = '{2'd1, 110, 1'b1, 1'b0, 2'd1};
        vecs[11] = '{2'd1, 114, 1'b1, 1'b1, 2'd1};
        vecs[12] = '{2'd1, 209, 1'b1, 1'b0, 2'd1};
        vecs[13] = '{2'd1, 210, 1'b0, 1'b0, 2'd0};
        vecs[14] = '{2'd3, 19,  1'b1, 1'b0, 2'd3};
        vecs[15] = '{2'd3, 20,  1'b1, 1'b1, 2'd3};
        vecs[16] = '{2'd3, 199, 1'b1, 1'b1, 2'd3};
        vecs[17] = '{2'd3, 200, 1'b0, 1'b0, 2'd0};

        // Reset state, including a command offered while reset is held.
        #1;
        check_idle("reset");
        step(2'd3);
        check_idle("reset_cmd");
        rst_n = 1'b1;
        step(2'd0);

        foreach (vecs[i]) begin
            go_idle();
            step(vecs[i].cmd);
            repeat (vecs[i].wait_cyc) step(2'd0);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_piezo", i), int'(piezo), int'(vecs[i].piezo));
            check($sformatf("vec%0d_cur", i), int'(cur), int'(vecs[i].cur));
        end

        // Preemption: Miss over Good at cycle 30, then a Perfect during the Miss is dropped.
        go_idle();
        step(2'd2);
        repeat (29) step(2'd0);
        step(2'd3);
        check("preempt_cur", int'(cur), 3);
        check("preempt_piezo", int'(piezo), 0);
        repeat (50) step(2'd0);
        step(2'd1);
        check("drop_cur", int'(cur), 3);
        repeat (148) step(2'd0);
        check("miss_last_busy", int'(busy), 1);
        step(2'd0);
        check_idle("miss_end");

        // Back-to-back: Good reissued on its own last cycle.
        go_idle();
        step(2'd2);
        repeat (99) step(2'd0);
        step(2'd2);
        check("b2b_busy", int'(busy), 1);
        check("b2b_piezo", int'(piezo), 0);
        repeat (99) step(2'd0);
        check("b2b_last_busy", int'(busy), 1);
        step(2'd0);
        check_idle("b2b_end");

        // Enable dropped mid-Perfect; Miss while disabled is ignored.
        go_idle();
        step(2'd1);
        repeat (40) step(2'd0);
        en = 1'b0;
        step(2'd0);
        check_idle("disable");
        step(2'd3);
        check_idle("disabled_cmd");
        repeat (5) step(2'd0);
        en = 1'b1;
        repeat (5) step(2'd0);
        check_idle("reenable");

        // Asynchronous reset mid-Miss, then silence after release.
        step(2'd3);
        repeat (30) step(2'd0);
        #3;
        rst_n = 1'b0;
        m_cmd = 0;
        m_e = 0;
        #1;
        check_idle("async_rst");
        repeat (3) step(2'd0);
        rst_n = 1'b1;
        repeat (20) step(2'd0);
        check_idle("post_rst");

        // Random commands and enable glitches against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] c;
            c = 2'd0;
            if ($urandom_range(0, 99) < 3) c = 2'($urandom_range(1, 3));
            en = ($urandom_range(0, 199) != 0);
            step(c);
        end
        en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sound_fx_player.md
SOUND_FX_PLAYER -- requirements
Module: sound_fx_player

Interface
REQ-001 SHALL have parameter HALF_PERF1, default 23878, giving the half-period in clocks of the Perfect first tone (~1047 Hz).
REQ-002 SHALL have parameter HALF_PERF2, default 18954, giving the half-period of the Perfect second tone (~1319 Hz).
REQ-003 SHALL have parameter HALF_GOOD, default 28409, giving the half-period of the Good tone (~880 Hz).
REQ-004 SHALL have parameter HALF_MISS, default 113636, giving the half-period of the Miss tone (~220 Hz).
REQ-005 SHALL have parameter TONE_LEN, default 4000000, giving the tone duration in clocks (80 ms at 50 MHz).
REQ-006 SHALL have parameter GAP_LEN, default 500000, giving the Perfect inter-tone silence in clocks.
REQ-007 SHALL have port i_Clk, input, 1 bit: 50 MHz clock.
REQ-008 SHALL have port i_Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port i_Sound_Cmd, input, 2 bits: one-cycle command (0 none, 1 Perfect, 2 Good, 3 Miss), driven by the game logic's registered output.
REQ-010 SHALL have port i_Enable, input, 1 bit: sound enable switch.
REQ-011 SHALL have port o_Piezo, output, 1 bit: square wave to the piezo buzzer.
REQ-012 SHALL have port o_Busy, output, 1 bit: high while an effect is playing.
REQ-013 SHALL have port o_Cur_Cmd, output, 2 bits: code of the effect currently playing, 0 when idle.

Function
REQ-014 SHALL implement states IDLE, TONE1, GAP and TONE2.
REQ-015 SHALL register all outputs.
REQ-016 SHALL sample a nonzero i_Sound_Cmd at clock edge N and enter TONE1 at N+1, with o_Busy=1 and o_Cur_Cmd=cmd from N+1.
REQ-017 SHALL use priorities Miss(3) > Perfect(1) > Good(2).
REQ-018 SHALL accept a new command while busy only if its priority is >= that of the playing effect; acceptance restarts TONE1 with both counters cleared and o_Piezo=0. A lower-priority command SHALL be dropped.
REQ-019 SHALL run Perfect as TONE1 (HALF_PERF1, TONE_LEN), then GAP (GAP_LEN, o_Piezo=0), then TONE2 (HALF_PERF2, TONE_LEN), then IDLE.
REQ-020 SHALL run Good as TONE1 (HALF_GOOD, TONE_LEN), then IDLE.
REQ-021 SHALL run Miss as TONE1 (HALF_MISS, 2*TONE_LEN), then IDLE.
REQ-022 SHALL, in a tone state, start o_Piezo at 0 and toggle it every HALF clocks: the half counter counts 0..HALF-1, toggles and wraps on HALF-1, so the first toggle occurs HALF cycles after state entry.
REQ-023 SHALL make each state last exactly its length in cycles, with the duration counter counting 0..LEN-1 and advancing on LEN-1.
REQ-024 SHALL force o_Piezo=0 on every entry to GAP or IDLE.
REQ-025 SHALL give a command arriving on the last cycle of an effect precedence over the return to IDLE: the effect restarts with no idle cycle.
REQ-026 SHALL, when i_Enable=0, go to IDLE on the next edge (o_Piezo=0, o_Busy=0, o_Cur_Cmd=0) and ignore commands.
REQ-027 SHALL size the counters for at least 2*TONE_LEN without overflow (32 bits).
REQ-028 SHALL drive o_Busy=1 exactly when the state is not IDLE.

Reset
REQ-029 SHALL, with i_Rst low, force state IDLE, o_Piezo=0, o_Busy=0, o_Cur_Cmd=0 and both counters to 0, asynchronously.
REQ-030 SHALL, on reset assertion mid-effect, abort the effect immediately, and SHALL play nothing after release until a new command arrives.

Verification
REQ-031 SHALL be verified with parameters HALF_PERF1=5, HALF_PERF2=4, HALF_GOOD=7, HALF_MISS=20, TONE_LEN=100, GAP_LEN=10 and i_Enable=1 unless stated.
REQ-032 SHALL verify Good: cmd=2 for 1 cycle -> o_Busy high for exactly 100 cycles; o_Piezo toggles every 7 cycles; then o_Piezo=0 and o_Cur_Cmd=0.
REQ-033 SHALL verify Perfect: cmd=1 -> 100 cycles at half-period 5, then 10 cycles of o_Piezo=0 with o_Busy=1, then 100 cycles at half-period 4; total busy 210 cycles.
REQ-034 SHALL verify preemption: cmd=2, then cmd=3 at cycle 30 -> Miss restarts and is busy 200 cycles from there; a cmd=1 issued during that Miss is ignored (o_Cur_Cmd stays 3).
REQ-035 SHALL verify back-to-back: cmd=2 on the last Good cycle -> o_Busy never drops; a new 100-cycle Good follows.
REQ-036 SHALL verify enable and reset: i_Enable=0 mid-Perfect -> idle on the next edge, and cmd=3 while disabled gives no output; i_Rst low mid-Miss -> outputs 0 immediately, with no activity after release.
